// File: rtl/alu32_seq.sv
// alu32_seq: registered 32-bit ALU execute stage with a start/done handshake.
// Single-cycle ops (AND, OR, ADD, SUB, SLT, and invalid codes) finish one edge
// after acceptance. MULT runs an iterative unsigned shift-add multiplier and
// finishes 32 edges after acceptance.
module alu32_seq #(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MULT = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    localparam logic [4:0] LAST_STEP = 5'(MUL_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MULT = 2'b10
    } state_t;

    state_t             state_r;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    // Product register {hi, lo}. The carry bit of the 65-bit shift-add
    // datapath exists only inside add_s: it is shifted into hi[MSB] on the
    // same edge it is produced, so it never needs to be held.
    logic [2*WIDTH-1:0] acc_r;
    logic [4:0]         cnt_r;

    logic [WIDTH-1:0]   sum_s;
    logic [WIDTH-1:0]   diff_s;
    logic               add_ovf_s;
    logic               sub_ovf_s;
    logic [WIDTH-1:0]   exec_res_s;
    logic               exec_ovf_s;
    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH:0]     add_s;
    logic [2*WIDTH-1:0] step_s;

    // Single-cycle result selection from the latched operands.
    always_comb begin
        sum_s      = a_r + b_r;
        diff_s     = a_r - b_r;
        add_ovf_s  = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
        sub_ovf_s  = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_s[WIDTH-1] != a_r[WIDTH-1]);
        exec_res_s = '0;
        exec_ovf_s = 1'b0;
        case (op_r)
            OP_AND: begin
                exec_res_s = a_r & b_r;
            end
            OP_OR: begin
                exec_res_s = a_r | b_r;
            end
            OP_ADD: begin
                exec_res_s = sum_s;
                exec_ovf_s = add_ovf_s;
            end
            OP_SUB: begin
                exec_res_s = diff_s;
                exec_ovf_s = sub_ovf_s;
            end
            OP_SLT: begin
                // Signed less-than: the sign of a-b corrected by its overflow.
                exec_res_s = {{(WIDTH-1){1'b0}}, diff_s[WIDTH-1] ^ sub_ovf_s};
            end
            default: begin
                exec_res_s = '0;
                exec_ovf_s = 1'b0;
            end
        endcase
    end

    // One shift-add multiply step: conditionally add a into hi, then shift right.
    always_comb begin
        if (acc_r[0]) begin
            addend_s = a_r;
        end else begin
            addend_s = '0;
        end
        add_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
        step_s = {add_s, acc_r[WIDTH-1:1]};
    end

    // Control FSM with registered handshake, result and flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            op_r      <= 3'b000;
            a_r       <= '0;
            b_r       <= '0;
            acc_r     <= '0;
            cnt_r     <= 5'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r <= op;
                        a_r  <= a;
                        b_r  <= b;
                        busy <= 1'b1;
                        if (op == OP_MULT) begin
                            acc_r   <= {{WIDTH{1'b0}}, b};
                            cnt_r   <= 5'd0;
                            state_r <= ST_MULT;
                        end else begin
                            state_r <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    result    <= exec_res_s;
                    result_hi <= '0;
                    zero      <= (exec_res_s == '0);
                    overflow  <= exec_ovf_s;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                ST_MULT: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r + 5'd1;
                    done  <= 1'b0;
                    if (cnt_r == LAST_STEP) begin
                        result    <= step_s[WIDTH-1:0];
                        result_hi <= step_s[2*WIDTH-1:WIDTH];
                        zero      <= (step_s == '0);
                        overflow  <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu32_seq.sv
// Self-checking bench for alu32_seq: directed scenarios plus randomized ops
// compared against a behavioural arithmetic model.
module tb_alu32_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        overflow;

    int pass_cnt;
    int total_cnt;

    alu32_seq #(.WIDTH(32), .MUL_STEPS(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arithmetic on signed/unsigned integers.
    function automatic void ref_alu(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic [31:0] h,
                                    output logic z, output logic v, output int lat);
        longint sx;
        longint sy;
        longint s;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r = 32'd0; h = 32'd0; v = 1'b0; lat = 1;
        case (o)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b010: begin s = sx + sy; r = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'b110: begin s = sx - sy; r = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'b111: r = (sx < sy) ? 32'd1 : 32'd0;
            3'b011: begin p = 64'(x) * 64'(y); r = p[31:0]; h = p[63:32]; lat = 32; end
            default: r = 32'd0;
        endcase
        z = ({h, r} == 64'd0);
    endfunction

    function automatic logic [31:0] rand_operand();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, scramble inputs after acceptance, count edges until done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b0; start = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
        #12;
        total_cnt++;
        if ({busy, done, result, result_hi, zero, overflow} !== 68'd0)
            $display("FAIL reset_state: got busy=%b done=%b res=%h hi=%h z=%b v=%b want all 0", busy, done, result, result_hi, zero, overflow);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        run_op(3'b001, 32'hF0F0_0000, 32'h0000_0F0F, lat);
        total_cnt++;
        if (lat !== 1) $display("FAIL or_latency: got %0d want 1", lat); else pass_cnt++;
        total_cnt++;
        if (result !== 32'hF0F0_0F0F || zero !== 1'b0 || busy !== 1'b0)
            $display("FAIL or_result: got res=%h z=%b busy=%b want F0F00F0F 0 0", result, zero, busy);
        else pass_cnt++;
        // Asynchronous assertion between edges clears outputs without a clock.
        @(negedge clk); #2; rst_n = 1'b0; #1;
        total_cnt++;
        if ({busy, done, result, result_hi, zero, overflow} !== 68'd0)
            $display("FAIL async_reset: got res=%h busy=%b want all 0", result, busy);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add_sub();
        int lat;
        run_op(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, lat);
        total_cnt++;
        if (result !== 32'h8000_0000 || overflow !== 1'b1 || zero !== 1'b0 || lat !== 1)
            $display("FAIL add_ovf: got res=%h v=%b z=%b lat=%0d want 80000000 1 0 1", result, overflow, zero, lat);
        else pass_cnt++;
        run_op(3'b110, 32'h1234_5678, 32'h1234_5678, lat);
        total_cnt++;
        if (result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0 || result_hi !== 32'd0)
            $display("FAIL sub_equal: got res=%h z=%b v=%b hi=%h want 0 1 0 0", result, zero, overflow, result_hi);
        else pass_cnt++;
    endtask

    task automatic test_slt();
        int lat;
        run_op(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, lat);
        total_cnt++;
        if (result !== 32'd1 || overflow !== 1'b0) $display("FAIL slt_neg1_lt_1: got %h want 1", result); else pass_cnt++;
        run_op(3'b111, 32'h0000_0001, 32'hFFFF_FFFF, lat);
        total_cnt++;
        if (result !== 32'd0 || zero !== 1'b1) $display("FAIL slt_1_lt_neg1: got %h z=%b want 0 1", result, zero); else pass_cnt++;
        run_op(3'b111, 32'h8000_0000, 32'h7FFF_FFFF, lat);
        total_cnt++;
        if (result !== 32'd1 || overflow !== 1'b0) $display("FAIL slt_ovf_path: got %h v=%b want 1 0", result, overflow); else pass_cnt++;
    endtask

    task automatic test_mult();
        int lat;
        int busy_bad;
        @(negedge clk);
        start = 1'b1; op = 3'b011; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        lat = 0; busy_bad = 0;
        while (lat < 100) begin
            @(negedge clk);
            start = 1'($urandom); op = 3'($urandom); a = $urandom; b = $urandom;
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (busy !== 1'b1) busy_bad++;
        end
        start = 1'b0;
        total_cnt++;
        if (lat !== 32) $display("FAIL mult_latency: got %0d want 32", lat); else pass_cnt++;
        total_cnt++;
        if (busy_bad !== 0) $display("FAIL mult_busy: got %0d low cycles want 0", busy_bad); else pass_cnt++;
        total_cnt++;
        if (result_hi !== 32'hFFFF_FFFE || result !== 32'h0000_0001 || busy !== 1'b0 || zero !== 1'b0)
            $display("FAIL mult_max: got hi=%h lo=%h busy=%b z=%b want FFFFFFFE 00000001 0 0", result_hi, result, busy, zero);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL done_pulse: got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        start = 1'b1; op = 3'b011; a = 32'h0000_1234; b = 32'h0000_0000;
        @(posedge clk); #1;
        @(negedge clk);
        op = 3'b000; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        total_cnt++;
        if (lat !== 32 || result !== 32'd0 || result_hi !== 32'd0 || zero !== 1'b1)
            $display("FAIL mult_zero: got lat=%0d hi=%h lo=%h z=%b want 32 0 0 1", lat, result_hi, result, zero);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done); else pass_cnt++;
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (done !== 1'b1 || result !== 32'hFFFF_FFFF || result_hi !== 32'd0 || zero !== 1'b0)
            $display("FAIL b2b_and: got done=%b res=%h hi=%h z=%b want 1 FFFFFFFF 0 0", done, result, result_hi, zero);
        else pass_cnt++;
    endtask

    task automatic test_abort_invalid();
        int lat;
        int saw_done;
        @(negedge clk);
        start = 1'b1; op = 3'b011; a = 32'hDEAD_BEEF; b = 32'h1357_9BDF;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst_n = 1'b0; #1;
        total_cnt++;
        if ({busy, done, result, result_hi, zero, overflow} !== 68'd0)
            $display("FAIL abort_outputs: got busy=%b res=%h hi=%h want all 0", busy, result, result_hi);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        saw_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) saw_done++;
        end
        total_cnt++;
        if (saw_done !== 0) $display("FAIL abort_no_done: got %0d active cycles want 0", saw_done); else pass_cnt++;
        run_op(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, lat);
        total_cnt++;
        if (lat !== 1 || result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0)
            $display("FAIL invalid_op: got lat=%0d res=%h z=%b v=%b want 1 0 1 0", lat, result, zero, overflow);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] er;
        logic [31:0] eh;
        logic        ez;
        logic        ev;
        int          elat;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom);
            x = rand_operand();
            y = rand_operand();
            ref_alu(o, x, y, er, eh, ez, ev, elat);
            run_op(o, x, y, lat);
            total_cnt++;
            if (lat !== elat || result !== er || result_hi !== eh || zero !== ez || overflow !== ev || busy !== 1'b0)
                $display("FAIL random_%0d op=%b a=%h b=%h: got lat=%0d hi=%h lo=%h z=%b v=%b want lat=%0d hi=%h lo=%h z=%b v=%b",
                         i, o, x, y, lat, result_hi, result, zero, overflow, elat, eh, er, ez, ev);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_add_sub();
        test_slt();
        test_mult();
        test_back_to_back();
        test_abort_invalid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu32_seq.md
Name: alu32_seq

Overview:
- Registered 32-bit ALU execute stage; consumes the outputs of the team's 32-bit bitwise gate arrays (AND/OR) and the adder/subtractor, and selects and latches the result.
- Adds a start/done handshake and an iterative 32-cycle unsigned shift-add multiplier.
- Sits between the register-file read stage and the writeback/result register in the hw4 datapath.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is supported.
- MUL_STEPS, 32, number of multiply iterations. Must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MULT; all other codes are invalid
- a  input  32  operand A; captured when start is accepted
- b  input  32  operand B; captured when start is accepted
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result, result_hi and flags are valid from this cycle
- result  output  32  low result word
- result_hi  output  32  upper product word for MULT; 0 for all other ops
- zero  output  1  result (and result_hi for MULT) all zero
- overflow  output  1  signed overflow for ADD/SUB; 0 otherwise

Behaviour:
- Reset is asynchronous and active-low. On reset, the state returns to IDLE and busy, done, result, result_hi, zero and overflow all become 0. The iteration counter and product register are cleared.
- States:
  - IDLE: waits for start.
  - EXEC: single-cycle ops.
  - MULT: multiply iterations.
- Start acceptance:
  - At the edge N where state == IDLE and start == 1, latch a, b and op, and set busy = 1.
  - MULT goes to MULT; every other op (including invalid codes) goes to EXEC.
  - start in EXEC or MULT is ignored. Operand changes after acceptance have no effect.
- EXEC, at edge N+1:
  - Register result, result_hi = 0 and the flags.
  - Set done = 1 and busy = 0, and go to IDLE.
- MULT:
  - A 65-bit register {carry, hi, lo} is initialised at acceptance with hi = 0 and lo = b.
  - Each MULT edge: if lo[0], hi += a with carry out; then shift the 65 bits right by 1.
  - A 5-bit counter counts 0..31. The edge with counter == 31 performs the last step and writes result = lo, result_hi = hi, done = 1, busy = 0, state = IDLE.
  - done therefore rises at edge N+32 after acceptance at edge N. The product is unsigned: {result_hi, result} = a*b.
- Arithmetic rules:
  - ADD: result = a + b mod 2^32. overflow = a[31]==b[31] && result[31]!=a[31].
  - SUB: result = a - b mod 2^32. overflow = a[31]!=b[31] && result[31]!=a[31].
  - SLT: result = {31'b0, (diff[31] ^ ovf_sub)}, a signed comparison; overflow output = 0.
  - AND/OR: bitwise; overflow = 0.
  - Invalid op: result = 0, zero = 1, overflow = 0, single-cycle timing.
- zero: (result == 0) for non-MULT ops; ({result_hi, result} == 0) for MULT.
- done is high for exactly one cycle. Outputs hold their values until the next done or reset.
- Back-to-back: the cycle in which done = 1 is already IDLE, so start sampled at that edge is accepted. Maximum throughput is one single-cycle op every 2 cycles.
- Reset asserted mid-MULT or mid-EXEC aborts the operation: no done, and outputs are zeroed.

Test Plan:
- Reset: hold rst_n = 0 mid-cycle -> all outputs 0 immediately with no clock edge. Release, then start with op=001, a=0xF0F0_0000, b=0x0000_0F0F -> done at the next edge, result=0xF0F0_0F0F, zero=0, busy low with done.
- ADD overflow: op=010, a=0x7FFF_FFFF, b=1 -> result=0x8000_0000, overflow=1. SUB with a=b=0x1234_5678 -> result=0, zero=1, overflow=0.
- SLT signed: a=0xFFFF_FFFF (-1), b=1 -> result=1. Then a=1, b=0xFFFF_FFFF -> result=0. Then a=0x8000_0000, b=0x7FFF_FFFF -> result=1 (overflow path).
- MULT: a=0xFFFF_FFFF, b=0xFFFF_FFFF -> busy for 32 cycles, done exactly 32 edges after acceptance, result_hi=0xFFFF_FFFE, result=0x0000_0001. Toggling start and operands during busy has no effect.
- MULT by zero plus back-to-back: a=0x1234, b=0 -> {hi,lo}=0, zero=1. start held high on the done cycle with op=000, a=b=0xFFFF_FFFF -> accepted, next done result=0xFFFF_FFFF, result_hi=0.
- Abort and invalid op: pull rst_n low at iteration 10 of a MULT -> no done pulse, outputs 0, state IDLE. Then op=100 -> result=0, zero=1, overflow=0, done after 1 cycle.
